prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader into instruction memory with length and XOR checksum
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_idx;
    logic [23:0]       word_buf;
    logic [7:0]        csum;

    logic              xfer;
    logic [15:0]       len_n;
    logic [ADDR_W:0]   next_idx;
    logic              len_oversize;

    // Transfer qualifier, candidate length and next word index
    always_comb begin
        xfer         = in_valid && in_ready;
        len_n        = {in_data, len_lo};
        next_idx     = word_idx + 1'b1;
        len_oversize = (32'(len_n) > (32'd1 << ADDR_W));
    end

    // Loader FSM with registered outputs; mem_we is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LEN0;
            len_lo    <= 8'd0;
            len       <= 16'd0;
            byte_cnt  <= 2'd0;
            word_idx  <= '0;
            word_buf  <= 24'd0;
            csum      <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN0: begin
                        len_lo <= in_data;
                        csum   <= csum ^ in_data;
                        state  <= S_LEN1;
                    end
                    S_LEN1: begin
                        len  <= len_n;
                        csum <= csum ^ in_data;
                        if (len_n == 16'd0) begin
                            state <= S_CSUM;
                        end else if (len_oversize) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {in_data, word_buf};
                                mem_addr  <= word_idx[ADDR_W-1:0];
                                word_idx  <= next_idx;
                                if (32'(next_idx) == 32'(len)) begin
                                    state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                    S_CSUM: begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERR are terminal; in_ready is low so no transfer arrives
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int n_checks;
    int n_errors;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          long_pulses;
    logic        prev_we;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
            if (prev_we) long_pulses++;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        long_pulses = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_one_word(input string tag, input logic [31:0] word);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check({tag, "_addr"}, 32'(wr_addr[0]), 32'd0);
            check({tag, "_data"}, wr_data[0], word);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    endtask

    logic [7:0] img2 [10];
    logic [7:0] img1 [7];
    int         gaps [7];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        long_pulses = 0;
        prev_we     = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;

        img2 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        img1 = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h01};
        gaps = '{0, 1, 2, 3, 0, 3, 1};

        // Reset state
        do_reset();
        check("rst_ready",  32'(in_ready),  32'd1);
        check("rst_we",     32'(mem_we),    32'd0);
        check("rst_addr",   32'(mem_addr),  32'd0);
        check("rst_wdata",  mem_wdata,      32'd0);
        check("rst_cpurst", 32'(cpu_reset), 32'd1);
        check("rst_done",   32'(done),      32'd0);
        check("rst_error",  32'(error),     32'd0);

        // Two-word image, good checksum 0x83
        for (int i = 0; i < 10; i++) begin
            send_byte(img2[i], 0);
            if (i == 5) begin
                check("ok_we_pulse", 32'(mem_we), 32'd1);
                check("ok_we_addr0", 32'(mem_addr), 32'd0);
            end
        end
        check("ok_pre_cpurst", 32'(cpu_reset), 32'd1);
        check("ok_pre_done",   32'(done),      32'd0);
        send_byte(8'h83, 0);
        check("ok_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("ok_a0", 32'(wr_addr[0]), 32'd0);
            check("ok_d0", wr_data[0], 32'h00100093);
            check("ok_a1", 32'(wr_addr[1]), 32'd1);
            check("ok_d1", wr_data[1], 32'h00100113);
        end
        check("ok_pulse_len", 32'(long_pulses), 32'd0);
        check("ok_done",   32'(done),      32'd1);
        check("ok_cpurst", 32'(cpu_reset), 32'd0);
        check("ok_ready",  32'(in_ready),  32'd0);
        check("ok_error",  32'(error),     32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ok_sticky", 32'(done), 32'd1);

        // Same image, inverted checksum
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img2[i], 0);
        send_byte(8'h7c, 0);
        check("bad_nwr",    32'(wr_addr.size()), 32'd2);
        check("bad_error",  32'(error),     32'd1);
        check("bad_done",   32'(done),      32'd0);
        check("bad_cpurst", 32'(cpu_reset), 32'd1);
        check("bad_ready",  32'(in_ready),  32'd0);

        // Empty image
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_predone", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        check("n0_nwr",  32'(wr_addr.size()), 32'd0);
        check("n0_done", 32'(done), 32'd1);

        // Oversize length 1025
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("big_error", 32'(error), 32'd1);
        check("big_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("big_nwr", 32'(wr_addr.size()), 32'd0);

        // Length 1024 is exactly capacity and is accepted
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        check("cap_error", 32'(error), 32'd0);
        check("cap_ready", 32'(in_ready), 32'd1);

        // One-word image, no gaps
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(img1[i], 0);
        check_one_word("w1", 32'hddccbbaa);

        // One-word image with idle gaps
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(img1[i], gaps[i]);
        check_one_word("gap", 32'hddccbbaa);
        check("gap_pulse_len", 32'(long_pulses), 32'd0);

        // Reset after two data bytes, then a fresh one-word image
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        send_byte(8'h45, 0);
        check_one_word("mid", 32'h11223344);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
